// File: rtl/ls2519_bank_ctl.sv
// Round-robin two-port sequencer for a bank of 25LS2519 quad registers.
// Generates clear, clock-enable, output-enable and invert strobes from registers only.
module ls2519_bank_ctl #(
    parameter int NREG   = 4,
    parameter int SELW   = 2,
    parameter int RD_CYC = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            REQ_A,
    input  logic            REQ_B,
    input  logic [1:0]      OP_A,
    input  logic [1:0]      OP_B,
    input  logic [SELW-1:0] SEL_A,
    input  logic [SELW-1:0] SEL_B,
    input  logic [3:0]      DIN_A,
    input  logic [3:0]      DIN_B,
    output logic            ACK_A,
    output logic            ACK_B,
    output logic [3:0]      I,
    output logic [NREG-1:0] CLK_ENB_N,
    output logic            INV,
    output logic [NREG-1:0] O_ENB_N,
    output logic [NREG-1:0] OUT_ENB_N,
    output logic            ASYN_CLR_N,
    output logic            BUSY,
    output logic            OWNER
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD,
        S_READ,
        S_ACK
    } state_t;

    state_t          state_q;
    logic [1:0]      clr_cnt_q;
    logic [3:0]      rd_cnt_q;
    logic            who_q;
    logic            ack_a_q;
    logic            ack_b_q;
    logic [3:0]      i_q;
    logic            inv_q;
    logic [NREG-1:0] cke_n_q;
    logic [NREG-1:0] oe_n_q;
    logic [NREG-1:0] oute_n_q;
    logic            clr_n_q;
    logic            busy_q;
    logic            owner_q;

    logic            go;
    logic            win_b;
    logic [1:0]      op_w;
    logic [SELW-1:0] sel_w;
    logic [3:0]      din_w;
    logic [NREG-1:0] sel_hot;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        go    = REQ_A | REQ_B;
        win_b = REQ_B & (~REQ_A | ~owner_q);
        op_w  = win_b ? OP_B : OP_A;
        sel_w = win_b ? SEL_B : SEL_A;
        din_w = win_b ? DIN_B : DIN_A;
        sel_hot = '0;
        for (int k = 0; k < NREG; k++) begin
            if (sel_w == SELW'(k)) sel_hot[k] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= 2'd2;
            rd_cnt_q  <= '0;
            who_q     <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            i_q       <= '0;
            inv_q     <= 1'b0;
            cke_n_q   <= '1;
            oe_n_q    <= '1;
            oute_n_q  <= '1;
            clr_n_q   <= 1'b0;
            busy_q    <= 1'b1;
            owner_q   <= 1'b1;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    if (clr_cnt_q == 2'd0) begin
                        state_q <= S_IDLE;
                        clr_n_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q - 2'd1;
                    end
                end
                S_IDLE: begin
                    if (go) begin
                        owner_q <= win_b;
                        who_q   <= win_b;
                        busy_q  <= 1'b1;
                        if (op_w[1]) begin
                            state_q  <= S_READ;
                            rd_cnt_q <= 4'(RD_CYC);
                            if (op_w[0]) oute_n_q <= ~sel_hot;
                            else         oe_n_q   <= ~sel_hot;
                        end else begin
                            state_q <= S_LOAD;
                            i_q     <= din_w;
                            inv_q   <= op_w[0];
                            cke_n_q <= ~sel_hot;
                        end
                    end
                end
                S_LOAD: begin
                    cke_n_q <= '1;
                    state_q <= S_ACK;
                    ack_a_q <= ~who_q;
                    ack_b_q <= who_q;
                end
                S_READ: begin
                    if (rd_cnt_q <= 4'd1) begin
                        oe_n_q   <= '1;
                        oute_n_q <= '1;
                        state_q  <= S_ACK;
                        ack_a_q  <= ~who_q;
                        ack_b_q  <= who_q;
                    end else begin
                        rd_cnt_q <= rd_cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    ack_a_q <= 1'b0;
                    ack_b_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign ACK_A      = ack_a_q;
    assign ACK_B      = ack_b_q;
    assign I          = i_q;
    assign INV        = inv_q;
    assign CLK_ENB_N  = cke_n_q;
    assign O_ENB_N    = oe_n_q;
    assign OUT_ENB_N  = oute_n_q;
    assign ASYN_CLR_N = clr_n_q;
    assign BUSY       = busy_q;
    assign OWNER      = owner_q;

endmodule

// File: tb/tb_ls2519_bank_ctl.sv
// Directed plus randomized transaction checks for ls2519_bank_ctl
// against a transaction-level model of the bank sequencer.
module tb_ls2519_bank_ctl;

    localparam int NREG   = 4;
    localparam int SELW   = 3;
    localparam int RD_CYC = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ_A = 1'b0, REQ_B = 1'b0;
    logic [1:0] OP_A = '0, OP_B = '0;
    logic [2:0] SEL_A = '0, SEL_B = '0;
    logic [3:0] DIN_A = '0, DIN_B = '0;
    logic       ACK_A, ACK_B, INV, ASYN_CLR_N, BUSY, OWNER;
    logic [3:0] I, CLK_ENB_N, O_ENB_N, OUT_ENB_N;

    int   n_cmp = 0;
    int   n_err = 0;
    logic [3:0] m_i;
    logic       m_inv;
    logic       m_owner;
    bit         w0, w1, w2, w3;

    ls2519_bank_ctl #(.NREG(NREG), .SELW(SELW), .RD_CYC(RD_CYC)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .OP_A(OP_A), .OP_B(OP_B),
        .SEL_A(SEL_A), .SEL_B(SEL_B),
        .DIN_A(DIN_A), .DIN_B(DIN_B),
        .ACK_A(ACK_A), .ACK_B(ACK_B),
        .I(I), .CLK_ENB_N(CLK_ENB_N), .INV(INV),
        .O_ENB_N(O_ENB_N), .OUT_ENB_N(OUT_ENB_N),
        .ASYN_CLR_N(ASYN_CLR_N), .BUSY(BUSY), .OWNER(OWNER)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] strb(input int s);
        logic [3:0] v;
        v = 4'hF;
        if (s < NREG) v[s] = 1'b0;
        return v;
    endfunction

    task automatic expect_cyc(input string tag, input logic aa, input logic ab,
                              input logic [3:0] ck, input logic [3:0] oe,
                              input logic [3:0] ou, input logic cl, input logic bs);
        logic [21:0] obs, exp;
        obs = {ACK_A, ACK_B, I, INV, CLK_ENB_N, O_ENB_N, OUT_ENB_N,
               ASYN_CLR_N, BUSY, OWNER};
        exp = {aa, ab, m_i, m_inv, ck, oe, ou, cl, bs, m_owner};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        m_owner = 1'b1;
        m_i = 4'h0;
        m_inv = 1'b0;
        repeat (n) begin
            step();
            expect_cyc("reset", 0, 0, 4'hF, 4'hF, 4'hF, 0, 1);
        end
        RESET = 1'b0;
        repeat (2) begin
            step();
            expect_cyc("clear", 0, 0, 4'hF, 4'hF, 4'hF, 0, 1);
        end
        step();
        expect_cyc("idle_after_clear", 0, 0, 4'hF, 4'hF, 4'hF, 1, 0);
    endtask

    // Starts and finishes at a sample point inside an IDLE cycle.
    task automatic do_txn(input logic ra, input logic rb,
                          input logic [1:0] oa, input logic [1:0] ob,
                          input logic [2:0] sa, input logic [2:0] sb,
                          input logic [3:0] da, input logic [3:0] db,
                          input bit hold, output bit win);
        logic [1:0] op;
        logic [2:0] sel;
        logic [3:0] ck, oe, ou;
        int len;
        REQ_A = ra; REQ_B = rb;
        OP_A = oa; OP_B = ob;
        SEL_A = sa; SEL_B = sb;
        DIN_A = da; DIN_B = db;
        if (!ra && !rb) begin
            win = m_owner;
            step();
            expect_cyc("no_req", 0, 0, 4'hF, 4'hF, 4'hF, 1, 0);
            return;
        end
        win = (ra && rb) ? ~m_owner : rb;
        op  = win ? ob : oa;
        sel = win ? sb : sa;
        len = op[1] ? RD_CYC : 1;
        step();
        if (!hold) begin
            REQ_A = 1'b0;
            REQ_B = 1'b0;
            OP_A = $urandom; OP_B = $urandom;
            SEL_A = $urandom; SEL_B = $urandom;
            DIN_A = $urandom; DIN_B = $urandom;
        end
        m_owner = win;
        if (!op[1]) begin
            m_i = win ? db : da;
            m_inv = op[0];
        end
        ck = op[1] ? 4'hF : strb(int'(sel));
        oe = (op == 2'b10) ? strb(int'(sel)) : 4'hF;
        ou = (op == 2'b11) ? strb(int'(sel)) : 4'hF;
        for (int k = 1; k <= len; k++) begin
            if (k > 1) step();
            expect_cyc("strobe", 0, 0, ck, oe, ou, 1, 1);
        end
        step();
        expect_cyc("ack", ~win, win, 4'hF, 4'hF, 4'hF, 1, 1);
        step();
        expect_cyc("idle", 0, 0, 4'hF, 4'hF, 4'hF, 1, 0);
    endtask

    initial begin
        m_i = 4'h0;
        m_inv = 1'b0;
        m_owner = 1'b1;
        #1;
        do_reset(3);

        do_txn(1, 0, 2'b00, 2'b00, 3'd2, 3'd0, 4'hA, 4'h0, 0, w0);

        do_reset(1);
        do_txn(1, 1, 2'b00, 2'b00, 3'd0, 3'd1, 4'h3, 4'hC, 1, w0);
        do_txn(1, 1, 2'b00, 2'b00, 3'd0, 3'd1, 4'h3, 4'hC, 1, w1);
        do_txn(1, 1, 2'b00, 2'b00, 3'd0, 3'd1, 4'h3, 4'hC, 1, w2);
        do_txn(1, 1, 2'b00, 2'b00, 3'd0, 3'd1, 4'h3, 4'hC, 1, w3);
        n_cmp++;
        assert ({w0, w1, w2, w3} === 4'b0101) else begin
            n_err++;
            $error("FAIL alternation: observed %b expected 0101", {w0, w1, w2, w3});
        end
        REQ_A = 1'b0;
        REQ_B = 1'b0;

        do_txn(0, 1, 2'b00, 2'b11, 3'd0, 3'd1, 4'h0, 4'h5, 0, w0);
        do_txn(1, 0, 2'b01, 2'b00, 3'd3, 3'd0, 4'h6, 4'h0, 0, w0);
        do_txn(1, 0, 2'b10, 2'b00, 3'd5, 3'd0, 4'h0, 4'h0, 0, w0);

        // Reset in the first strobe cycle of a read.
        REQ_B = 1'b1; OP_B = 2'b10; SEL_B = 3'd0;
        step();
        REQ_B = 1'b0;
        m_owner = 1'b1;
        expect_cyc("read_pre_reset", 0, 0, 4'hF, strb(0), 4'hF, 1, 1);
        do_reset(1);

        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                   3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom), w0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ls2519_bank_ctl.md
# ls2519_bank_ctl

Sequencer and two-port arbiter for a bank of 25LS2519 quad registers (NREG devices, 4 bits each). It shares the bank between requesters A and B with round-robin arbitration and generates per-device clock-enable, output-enable, invert and clear strobes. It drives the shared 4-bit register input bus, and clears the whole bank after reset. It sits between microcode-side requesters and the 2519 register parts on the CADR datapath.

## Interface
Parameters:
- NREG, 4: number of 25LS2519 devices controlled
- SELW, 2: width of register-select field; must satisfy 2**SELW >= NREG
- RD_CYC, 2: cycles an output enable is held for a read (1..15)

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ_A, REQ_B  in  1  request from requester A / B
- OP_A, OP_B  in  2  00 load, 01 load-inverted, 10 read via A outputs, 11 read via B outputs
- SEL_A, SEL_B  in  SELW  target device index
- DIN_A, DIN_B  in  4  load data
- ACK_A, ACK_B  out  1  one-cycle completion pulse
- I  out  4  data to device I0..I3 (shared bus)
- CLK_ENB_N  out  NREG  per-device clock enable, active low
- INV  out  1  invert control to all devices
- O_ENB_N  out  NREG  per-device A-output enable, active low
- OUT_ENB_N  out  NREG  per-device B-output enable, active low
- ASYN_CLR_N  out  1  bank clear, active low
- BUSY  out  1  high in every state except IDLE
- OWNER  out  1  0 = A, 1 = B; last granted requester

## Operation
- States: CLEAR, IDLE, LOAD, READ, ACK.
- RESET high: state forced to CLEAR at the next edge. Outputs during and after reset: all CLK_ENB_N, O_ENB_N and OUT_ENB_N bits 1; INV 0; I 0; ACK_A/B 0; BUSY 1; ASYN_CLR_N 0; OWNER 1, so A wins the first tie.
- CLEAR: ASYN_CLR_N held 0 while RESET is high and for 2 cycles after RESET falls, then IDLE.
- IDLE: a request is granted if exactly one REQ is high. If both are high, grant the requester not equal to OWNER. At the grant edge, OP, SEL and DIN of the winner are latched and OWNER is updated. Next state is LOAD for OP 0x, READ for OP 1x.
- Requester inputs need only be valid in the grant cycle.
- LOAD: one cycle. I = latched DIN, INV = OP[0], CLK_ENB_N[SEL] = 0; all other enables stay 1. Next state is ACK.
- READ: O_ENB_N[SEL] = 0 (OP 10) or OUT_ENB_N[SEL] = 0 (OP 11) for exactly RD_CYC cycles via a down-counter. Next state is ACK.
- ACK: the granted requester's ACK is 1 for one cycle; all strobes are inactive; next state is IDLE.
- A REQ still high in the IDLE cycle after ACK is a new request.
- SEL >= NREG: no strobe asserts. The operation still completes and acknowledges with unchanged latency.
- At most one bit across CLK_ENB_N, O_ENB_N and OUT_ENB_N is low in any cycle.
- I and INV change only on entry to LOAD. They hold their values otherwise, except that reset zeroes them.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Load: REQ seen in IDLE at cycle 0 → strobe in cycle 1 → ACK in cycle 2 → IDLE in cycle 3.
- Read: enable in cycles 1..RD_CYC → ACK in cycle RD_CYC+1.
- Back-to-back throughput: one load per 3 cycles.
- RESET mid-operation: all strobes deassert and ACK is suppressed at the next edge; the state enters CLEAR, and any latched operation is discarded.
- A request arriving while BUSY waits, with no loss, provided REQ is held.

## Test plan
- Reset then release: ASYN_CLR_N low for the reset cycles plus exactly 2 more, BUSY falls in the following cycle, and all enables are 1.
- A only, OP 00, SEL 2, DIN 0xA: CLK_ENB_N = 1011 and I = 0xA, INV = 0 in cycle 1; ACK_A in cycle 2; ACK_B stays 0.
- REQ_A and REQ_B high together and held for 4 transactions: grants alternate A, B, A, B, and OWNER toggles each time.
- B, OP 11, SEL 1, RD_CYC 2: OUT_ENB_N = 1101 for exactly 2 cycles; ACK_B in cycle 3; O_ENB_N stays 1111.
- A, OP 01, SEL 3: INV = 1 with CLK_ENB_N = 0111. Then A, OP 10, SEL 5: no enable asserts and ACK_A arrives in cycle RD_CYC+1.
- RESET asserted during cycle 1 of a READ: at the next edge the enables return to 1, no ACK is issued, and the CLEAR sequence repeats.
